// File: rtl/secded_decod_pipe.sv
// Two-stage SECDED Hamming decoder with valid/ready flow control
// and saturating corrected/uncorrectable word counters.
module secded_decod_pipe #(
  parameter int n = 8,
  parameter int k = 4,
  parameter int cw = 16,
  localparam int r = n - 1 - k
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [n-1:0]  in1,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          secded_en,
  output logic [n-1:0]  out1,
  output logic [k-1:0]  dout,
  output logic [r-1:0]  syndrome,
  output logic [1:0]    err,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          clr_cnt,
  output logic [cw-1:0] cnt_corr,
  output logic [cw-1:0] cnt_uncorr
);

  logic          s1_valid_q;
  logic [n-1:0]  s1_cw_q;
  logic          s1_sec_q;
  logic [r-1:0]  s1_syn_q;
  logic          s1_par_q;

  logic          s2_valid_q;
  logic [n-1:0]  out1_q;
  logic [k-1:0]  dout_q;
  logic [r-1:0]  syn_q;
  logic [1:0]    err_q;

  logic [cw-1:0] cnt_corr_q, cnt_corr_d;
  logic [cw-1:0] cnt_uncorr_q, cnt_uncorr_d;

  logic          s1_adv;
  logic          hs;
  logic [r-1:0]  syn_c;
  logic          par_c;
  logic [n-1:0]  mask;
  logic [n-1:0]  flip;
  logic          in_rng;
  logic          zs;
  logic          dbl;
  logic [1:0]    err_c;
  logic [n-1:0]  corr_c;
  logic [k-1:0]  dout_c;
  int            d;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign hs       = s2_valid_q && out_ready;

  always_comb begin
    syn_c = '0;
    for (int j = 0; j < r; j++) begin
      for (int i = 0; i < n - 1; i++) begin
        if ((((i + 1) >> j) & 1) == 1) begin
          syn_c[j] = syn_c[j] ^ in1[i];
        end
      end
    end
  end

  assign par_c = ^in1;

  always_comb begin
    mask   = '0;
    in_rng = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      if (s1_syn_q == r'(i + 1)) begin
        mask[i] = 1'b1;
        in_rng  = 1'b1;
      end
    end
  end

  assign zs  = (s1_syn_q == '0);
  assign dbl = s1_sec_q && !s1_par_q;

  // Conditions are kept mutually exclusive for the unique decoder.
  always_comb begin
    flip  = '0;
    err_c = 2'b00;
    unique case (1'b1)
      zs && !(s1_sec_q && s1_par_q): begin
        err_c = 2'b00;
      end
      zs && s1_sec_q && s1_par_q: begin
        flip[n-1] = 1'b1;
        err_c     = 2'b01;
      end
      !zs && dbl: begin
        err_c = 2'b10;
      end
      !zs && !dbl && !in_rng: begin
        err_c = 2'b10;
      end
      !zs && !dbl && in_rng: begin
        flip  = mask;
        err_c = 2'b01;
      end
      default: begin
        err_c = 2'b00;
      end
    endcase
  end

  assign corr_c = s1_cw_q ^ flip;

  always_comb begin
    dout_c = '0;
    d      = 0;
    for (int i = 0; i < n - 1; i++) begin
      if (((i + 1) & i) != 0) begin
        if (d < k) begin
          dout_c[d] = corr_c[i];
        end
        d = d + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_sec_q   <= 1'b0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cw_q  <= in1;
        s1_sec_q <= secded_en;
        s1_syn_q <= syn_c;
        s1_par_q <= par_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out1_q     <= '0;
      dout_q     <= '0;
      syn_q      <= '0;
      err_q      <= 2'b00;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out1_q <= corr_c;
        dout_q <= dout_c;
        syn_q  <= s1_syn_q;
        err_q  <= err_c;
      end
    end
  end

  // Clear takes priority over a same-cycle handshake.
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (clr_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (hs) begin
      if (err_q == 2'b01 && cnt_corr_q != '1) begin
        cnt_corr_d = cnt_corr_q + cw'(1);
      end
      if (err_q == 2'b10 && cnt_uncorr_q != '1) begin
        cnt_uncorr_d = cnt_uncorr_q + cw'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out1       = out1_q;
  assign dout       = dout_q;
  assign syndrome   = syn_q;
  assign err        = err_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_secded_decod_pipe.sv
// Bench for secded_decod_pipe: queue-based decoder model plus
// directed literal vectors, on a cw=16 and a cw=2 instance.
module tb_secded_decod_pipe;

  localparam int N = 8;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] in1;
  logic in_valid;
  logic secded_en;
  logic out_ready;
  logic clr_cnt;

  logic in_ready, out_valid;
  logic [N-1:0] out1;
  logic [K-1:0] dout;
  logic [2:0] syndrome;
  logic [1:0] err;
  logic [15:0] cnt_corr, cnt_uncorr;

  logic s_in_ready, s_out_valid;
  logic [N-1:0] s_out1;
  logic [K-1:0] s_dout;
  logic [2:0] s_syndrome;
  logic [1:0] s_err;
  logic [1:0] s_cnt_corr, s_cnt_uncorr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0] o;
    logic [K-1:0] d;
    logic [2:0]   s;
    logic [1:0]   e;
    int           stamp;
  } exp_t;

  exp_t q[$];
  int mc, mu, sc, su;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  secded_decod_pipe #(.n(8), .k(4), .cw(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in_valid(in_valid),
    .in_ready(in_ready), .secded_en(secded_en), .out1(out1),
    .dout(dout), .syndrome(syndrome), .err(err),
    .out_valid(out_valid), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  secded_decod_pipe #(.n(8), .k(4), .cw(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in_valid(in_valid),
    .in_ready(s_in_ready), .secded_en(secded_en), .out1(s_out1),
    .dout(s_dout), .syndrome(s_syndrome), .err(s_err),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .cnt_corr(s_cnt_corr),
    .cnt_uncorr(s_cnt_uncorr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] w, input logic sec);
    exp_t e;
    int s;
    int di;
    bit p;
    s = 0;
    for (int i = 0; i < N - 1; i++) if (w[i]) s = s ^ (i + 1);
    p = ^w;
    e.o = w;
    e.e = 2'd0;
    e.d = '0;
    e.stamp = 0;
    if (sec && s == 0 && p) begin
      e.o[N-1] = ~e.o[N-1];
      e.e = 2'd1;
    end else if (sec && s != 0 && !p) begin
      e.e = 2'd2;
    end else if (s != 0) begin
      if (s <= N - 1) begin
        e.o[s-1] = ~e.o[s-1];
        e.e = 2'd1;
      end else begin
        e.e = 2'd2;
      end
    end
    e.s = 3'(s);
    di = 0;
    for (int pos = 1; pos < N; pos++) begin
      if ($countones(pos) != 1) begin
        e.d[di] = e.o[pos-1];
        di++;
      end
    end
    return e;
  endfunction

  initial begin
    bit ov, ir;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        mc = 0; mu = 0; sc = 0; su = 0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out1", 32'(out1), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_syndrome", 32'(syndrome), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt_corr", 32'(cnt_corr), 0);
        chk("rst_cnt_uncorr", 32'(cnt_uncorr), 0);
        chk("rst_sat_cnt", 32'(s_cnt_corr), 0);
      end else begin
        ov = (q.size() > 0) && (cyc >= q[0].stamp + 2);
        ir = (q.size() < 2) || out_ready;
        chk("in_ready", 32'(in_ready), 32'(ir));
        chk("sat_in_ready", 32'(s_in_ready), 32'(ir));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("sat_out_valid", 32'(s_out_valid), 32'(ov));
        if (ov) begin
          chk("out1", 32'(out1), 32'(q[0].o));
          chk("dout", 32'(dout), 32'(q[0].d));
          chk("syndrome", 32'(syndrome), 32'(q[0].s));
          chk("err", 32'(err), 32'(q[0].e));
          chk("sat_out1", 32'(s_out1), 32'(q[0].o));
          chk("sat_err", 32'(s_err), 32'(q[0].e));
        end
        chk("cnt_corr", 32'(cnt_corr), 32'(mc));
        chk("cnt_uncorr", 32'(cnt_uncorr), 32'(mu));
        chk("sat_cnt_corr", 32'(s_cnt_corr), 32'(sc));
        chk("sat_cnt_uncorr", 32'(s_cnt_uncorr), 32'(su));
        if (clr_cnt) begin
          mc = 0; mu = 0; sc = 0; su = 0;
        end else if (ov && out_ready) begin
          if (q[0].e == 2'd1) begin
            if (mc < 65535) mc++;
            if (sc < 3) sc++;
          end
          if (q[0].e == 2'd2) begin
            if (mu < 65535) mu++;
            if (su < 3) su++;
          end
        end
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) begin
          e = model(in1, secded_en);
          e.stamp = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send_lit(input logic [N-1:0] w, input logic sec,
                          input logic [N-1:0] eo, input logic [K-1:0] ed,
                          input logic [2:0] es, input logic [1:0] ee,
                          input logic clr_at_out);
    @(posedge clk); #1;
    in1 = w; secded_en = sec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("lit_out_valid", 32'(out_valid), 1);
    chk("lit_out1", 32'(out1), 32'(eo));
    chk("lit_dout", 32'(dout), 32'(ed));
    chk("lit_syndrome", 32'(syndrome), 32'(es));
    chk("lit_err", 32'(err), 32'(ee));
    clr_cnt = clr_at_out;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] words [8];
    int n;
    words = '{8'h55, 8'h51, 8'hD5, 8'h56, 8'h00, 8'hFF, 8'h0F, 8'h33};
    rst_n = 1'b0; in1 = '0; in_valid = 1'b0;
    secded_en = 1'b1; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send_lit(8'h55, 1'b1, 8'h55, 4'hB, 3'd0, 2'd0, 1'b0);
    chk("lit_cc_55", 32'(cnt_corr), 0);
    send_lit(8'h51, 1'b1, 8'h55, 4'hB, 3'd3, 2'd1, 1'b0);
    chk("lit_cc_51", 32'(cnt_corr), 1);
    send_lit(8'hD5, 1'b1, 8'h55, 4'hB, 3'd0, 2'd1, 1'b0);
    chk("lit_cc_d5", 32'(cnt_corr), 2);
    send_lit(8'h56, 1'b1, 8'h56, 4'hB, 3'd3, 2'd2, 1'b0);
    chk("lit_cu_56", 32'(cnt_uncorr), 1);
    send_lit(8'h56, 1'b0, 8'h52, 4'hA, 3'd3, 2'd1, 1'b0);
    chk("lit_cc_56sec", 32'(cnt_corr), 3);

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in1 = words[i];
          secded_en = (i % 3 != 2);
          in_valid = 1'b1;
          n = 0;
          @(negedge clk);
          while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
          end
          if (n >= 20) chk("stream_accept_timeout", 32'(n), 0);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stream_drain", 32'(q.size()), 0);

    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_cc", 32'(cnt_corr), 0);
    chk("clr_cu", 32'(cnt_uncorr), 0);
    chk("clr_sat", 32'(s_cnt_corr), 0);

    for (int i = 0; i < 5; i++)
      send_lit(8'h51, 1'b1, 8'h55, 4'hB, 3'd3, 2'd1, 1'b0);
    chk("five_cc", 32'(cnt_corr), 5);
    chk("sat_cc", 32'(s_cnt_corr), 3);

    out_ready = 1'b0;
    @(posedge clk); #1;
    in1 = 8'h51; secded_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_cc", 32'(cnt_corr), 0);
    chk("arst_sat", 32'(s_cnt_corr), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send_lit(8'h51, 1'b1, 8'h55, 4'hB, 3'd3, 2'd1, 1'b0);
    chk("post_rst_cc", 32'(cnt_corr), 1);
    send_lit(8'h51, 1'b1, 8'h55, 4'hB, 3'd3, 2'd1, 1'b1);
    chk("clr_wins_cc", 32'(cnt_corr), 0);
    chk("clr_wins_sat", 32'(s_cnt_corr), 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
